// File: rtl/score_keeper_if.sv
// Game-status bus between the column layer and the score keeper.
// Carries per-column flags, start, and the score/lives/state outputs.
interface score_keeper_if #(
  parameter int NUM_COLUMNS = 3
);
  logic [NUM_COLUMNS-1:0] correct;
  logic [NUM_COLUMNS-1:0] game_over;
  logic                   start;
  logic [15:0]            score_bcd;
  logic [15:0]            high_score_bcd;
  logic [2:0]             lives;
  logic                   playing;
  logic                   all_over;
  logic                   columns_reset;

  modport master (
    output correct,
    output game_over,
    output start,
    input  score_bcd,
    input  high_score_bcd,
    input  lives,
    input  playing,
    input  all_over,
    input  columns_reset
  );

  modport slave (
    input  correct,
    input  game_over,
    input  start,
    output score_bcd,
    output high_score_bcd,
    output lives,
    output playing,
    output all_over,
    output columns_reset
  );
endinterface

// File: rtl/score_keeper.sv
// Score, lives and high-score keeper with IDLE/PLAY/OVER sequencing.
// Counts rising edges of per-column correct/game_over flags.
module score_keeper #(
  parameter int NUM_COLUMNS = 3,
  parameter int START_LIVES = 3
) (
  input logic           clock,
  input logic           reset_signal,
  score_keeper_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    OVER
  } state_e;

  localparam logic [2:0] LIVES0 = 3'(START_LIVES);

  state_e state_q, state_d;

  logic [NUM_COLUMNS-1:0] corr_h_q;
  logic [NUM_COLUMNS-1:0] go_h_q;
  logic                   start_h_q;

  logic [15:0] score_q, score_d;
  logic [15:0] high_q, high_d;
  logic [2:0]  lives_q, lives_d;
  logic        first_q, first_d;
  logic        play_q, play_d;
  logic        over_q, over_d;
  logic        crst_q, crst_d;

  logic [NUM_COLUMNS-1:0] corr_e;
  logic [NUM_COLUMNS-1:0] go_e;
  logic                   start_e;
  logic [3:0]             hits;
  logic [3:0]             miss;

  function automatic logic [3:0] popcnt(
    input logic [NUM_COLUMNS-1:0] v
  );
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_COLUMNS; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

  // Ripple decimal add of a small value; a carry out of the top
  // digit means the true result exceeds 9999.
  function automatic logic [15:0] bcd_add(
    input logic [15:0] s,
    input logic [3:0]  inc
  );
    logic [15:0] r;
    logic [4:0]  t;
    logic [3:0]  a;
    logic        cy;
    r  = s;
    a  = inc;
    cy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t = {1'b0, s[4*i +: 4]} + {1'b0, a};
      if (t > 5'd9) begin
        r[4*i +: 4] = 4'(t - 5'd10);
        cy          = 1'b1;
      end else begin
        r[4*i +: 4] = t[3:0];
        cy          = 1'b0;
      end
      a = {3'b000, cy};
    end
    if (cy) r = 16'h9999;
    return r;
  endfunction

  assign corr_e  = bus.correct & ~corr_h_q;
  assign go_e    = bus.game_over & ~go_h_q;
  assign start_e = bus.start & ~start_h_q;
  assign hits    = popcnt(corr_e);
  assign miss    = popcnt(go_e);

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    high_d  = high_q;
    first_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_e) begin
          state_d = PLAY;
          score_d = '0;
          lives_d = LIVES0;
        end
      end
      PLAY: begin
        score_d = bcd_add(score_q, hits);
        if (miss != 4'd0) begin
          if (miss >= {1'b0, lives_q}) begin
            lives_d = '0;
            state_d = OVER;
            first_d = 1'b1;
          end else begin
            lives_d = lives_q - miss[2:0];
          end
        end
      end
      OVER: begin
        // Valid BCD orders the same as binary.
        if (first_q && (score_q > high_q)) begin
          high_d = score_q;
        end
        if (start_e) begin
          state_d = PLAY;
          score_d = '0;
          lives_d = LIVES0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    play_d = (state_d == PLAY);
    over_d = (state_d == OVER);
    crst_d = (state_d != PLAY);
  end

  always_ff @(posedge clock) begin
    if (!reset_signal) begin
      state_q   <= IDLE;
      corr_h_q  <= '0;
      go_h_q    <= '0;
      start_h_q <= 1'b0;
      score_q   <= '0;
      high_q    <= '0;
      lives_q   <= LIVES0;
      first_q   <= 1'b0;
      play_q    <= 1'b0;
      over_q    <= 1'b0;
      crst_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      corr_h_q  <= bus.correct;
      go_h_q    <= bus.game_over;
      start_h_q <= bus.start;
      score_q   <= score_d;
      high_q    <= high_d;
      lives_q   <= lives_d;
      first_q   <= first_d;
      play_q    <= play_d;
      over_q    <= over_d;
      crst_q    <= crst_d;
    end
  end

  assign bus.score_bcd      = score_q;
  assign bus.high_score_bcd = high_q;
  assign bus.lives          = lives_q;
  assign bus.playing        = play_q;
  assign bus.all_over       = over_q;
  assign bus.columns_reset  = crst_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: integer game model plus directed games.
// Outputs are compared on every falling edge once reset has run.
module tb_score_keeper;

  localparam int NC = 3;
  localparam int SL = 3;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  bit   cmp_en;

  score_keeper_if #(.NUM_COLUMNS(NC)) bus ();

  score_keeper #(
    .NUM_COLUMNS(NC),
    .START_LIVES(SL)
  ) dut (
    .clock       (clk),
    .reset_signal(rst_n),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Model: plain integers, 0=idle 1=play 2=over.
  int       m_st;
  int       m_score;
  int       m_high;
  int       m_lives;
  int       m_final;
  bit       m_pend;
  logic [NC-1:0] p_c;
  logic [NC-1:0] p_g;
  logic          p_s;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit bcd_ok(input logic [15:0] v);
    return (v[3:0] <= 9) && (v[7:4] <= 9) &&
           (v[11:8] <= 9) && (v[15:12] <= 9);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int  kc;
    int  mg;
    bit  se;
    if (!rst_n) begin
      m_st    = 0;
      m_score = 0;
      m_high  = 0;
      m_lives = SL;
      m_pend  = 0;
      p_c     = '0;
      p_g     = '0;
      p_s     = 1'b0;
    end else begin
      kc = $countones(bus.correct & ~p_c);
      mg = $countones(bus.game_over & ~p_g);
      se = bus.start && !p_s;
      if (m_pend) begin
        if (m_final > m_high) m_high = m_final;
        m_pend = 0;
      end
      if (m_st == 1) begin
        m_score = m_score + kc;
        if (m_score > 9999) m_score = 9999;
        m_lives = m_lives - mg;
        if (m_lives <= 0) begin
          m_lives = 0;
          m_st    = 2;
          m_final = m_score;
          m_pend  = 1;
        end
      end else if (se) begin
        m_st    = 1;
        m_score = 0;
        m_lives = SL;
      end
      p_c = bus.correct;
      p_g = bus.game_over;
      p_s = bus.start;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("score", bus.score_bcd, to_bcd(m_score));
      chk("high", bus.high_score_bcd, to_bcd(m_high));
      chk("lives", {13'd0, bus.lives}, 16'(m_lives));
      chk("playing", {15'd0, bus.playing}, 16'(m_st == 1));
      chk("all_over", {15'd0, bus.all_over}, 16'(m_st == 2));
      chk("col_rst", {15'd0, bus.columns_reset},
          16'(m_st != 1));
      chk("bcd_digits", 16'(bcd_ok(bus.score_bcd) &&
          bcd_ok(bus.high_score_bcd)), 16'd1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [NC-1:0] v);
    bus.correct = v;
    tick(1);
    bus.correct = '0;
    tick(1);
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic miss(input logic [NC-1:0] v);
    bus.game_over = v;
    tick(1);
    bus.game_over = '0;
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    cmp_en        = 0;
    rst_n         = 1'b0;
    bus.correct   = '0;
    bus.game_over = '0;
    bus.start     = 1'b0;
    tick(1);
    cmp_en = 1;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("rst_score", bus.score_bcd, 16'h0000);
    chk("rst_high", bus.high_score_bcd, 16'h0000);
    chk("rst_lives", {13'd0, bus.lives}, 16'd3);
    chk("rst_crst", {15'd0, bus.columns_reset}, 16'd1);

    // Game 1: correct already high on start must not count.
    bus.correct = 3'b001;
    start_game();
    chk("g1_play", {15'd0, bus.playing}, 16'd1);
    chk("g1_crst", {15'd0, bus.columns_reset}, 16'd0);
    chk("g1_prehigh", bus.score_bcd, 16'h0000);
    bus.correct = '0;
    tick(1);
    bus.correct = 3'b001;
    tick(1);
    chk("g1_one", bus.score_bcd, 16'h0001);
    tick(10);
    chk("g1_held", bus.score_bcd, 16'h0001);
    bus.correct = '0;
    tick(1);
    pulse(3'b001);
    chk("g1_two", bus.score_bcd, 16'h0002);
    bus.correct   = 3'b010;
    bus.game_over = 3'b101;
    tick(1);
    chk("g1_mix_score", bus.score_bcd, 16'h0003);
    chk("g1_mix_lives", {13'd0, bus.lives}, 16'd1);
    bus.correct   = '0;
    bus.game_over = '0;
    tick(1);
    pulse(3'b001);
    pulse(3'b100);
    miss(3'b001);
    chk("g1_over", {15'd0, bus.all_over}, 16'd1);
    chk("g1_lives0", {13'd0, bus.lives}, 16'd0);
    tick(1);
    chk("g1_high", bus.high_score_bcd, 16'h0005);

    // Game 2 scores less; high score must hold.
    start_game();
    chk("g2_score0", bus.score_bcd, 16'h0000);
    chk("g2_lives", {13'd0, bus.lives}, 16'd3);
    pulse(3'b001);
    pulse(3'b010);
    pulse(3'b100);
    miss(3'b111);
    tick(2);
    chk("g2_high", bus.high_score_bcd, 16'h0005);

    // Game 3: start on the first OVER cycle.
    start_game();
    pulse(3'b111);
    pulse(3'b111);
    pulse(3'b001);
    bus.game_over = 3'b111;
    tick(1);
    chk("g3_over", {15'd0, bus.all_over}, 16'd1);
    bus.game_over = '0;
    bus.start     = 1'b1;
    tick(1);
    bus.start = 1'b0;
    chk("g3_high", bus.high_score_bcd, 16'h0007);
    chk("g3_replay", {15'd0, bus.playing}, 16'd1);
    chk("g3_score0", bus.score_bcd, 16'h0000);

    // Game 3 continued: decimal carry and saturation.
    for (int i = 0; i < 332; i++) pulse(3'b111);
    pulse(3'b010);
    pulse(3'b010);
    chk("g3_998", bus.score_bcd, 16'h0998);
    pulse(3'b111);
    chk("g3_1001", bus.score_bcd, 16'h1001);
    for (int i = 0; i < 2999; i++) pulse(3'b111);
    chk("g3_9998", bus.score_bcd, 16'h9998);
    pulse(3'b111);
    chk("g3_sat", bus.score_bcd, 16'h9999);
    pulse(3'b111);
    chk("g3_sat2", bus.score_bcd, 16'h9999);
    miss(3'b111);
    tick(1);
    chk("g3_high9999", bus.high_score_bcd, 16'h9999);

    // Game 4: reset mid-play discards everything.
    start_game();
    for (int i = 0; i < 14; i++) pulse(3'b111);
    chk("g4_42", bus.score_bcd, 16'h0042);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("g4_rst_score", bus.score_bcd, 16'h0000);
    chk("g4_rst_high", bus.high_score_bcd, 16'h0000);
    chk("g4_rst_play", {15'd0, bus.playing}, 16'd0);
    chk("g4_rst_crst", {15'd0, bus.columns_reset}, 16'd1);
    tick(3);
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Downstream consumer of the per-column state machines. Watches each column's `correct` and `game_over` flags and keeps the score, lives and high score.
- Sequences the game through IDLE / PLAY / OVER and drives the column reset.
- Outputs (BCD score, lives, state flags) feed the 7-segment / LED layer and gate the columns.

Parameters:
- NUM_COLUMNS, 3, number of column state machines monitored (1..9).
- START_LIVES, 3, lives loaded at game start (1..7).

Ports:
- clock  input  1  system clock (50 MHz).
- reset_signal  input  1  synchronous, active-low reset.
- correct  input  NUM_COLUMNS  per-column "letter matched" level; a rising edge = one point.
- game_over  input  NUM_COLUMNS  per-column "letter reached bottom" level; a rising edge = one miss.
- start  input  1  start-game request; acted on at its rising edge.
- score_bcd  output  16  current score, 4 BCD digits, [15:12] most significant.
- high_score_bcd  output  16  best score since reset, 4 BCD digits.
- lives  output  3  remaining lives.
- playing  output  1  high in PLAY.
- all_over  output  1  high in OVER.
- columns_reset  output  1  active-high reset to all columns. High in IDLE and OVER, low in PLAY.

Behaviour:
- Reset: sampled on the clock edge while reset_signal == 0. All outputs are registered. Values forced on reset:
  - state = IDLE
  - score_bcd = 0, high_score_bcd = 0, lives = START_LIVES
  - playing = 0, all_over = 0, columns_reset = 1
  - all edge-history registers = 0
- Reset mid-game: abandons the game immediately, with no high-score update.
- Edge detection:
  - One history flop per bit of correct, game_over and start.
  - Edge = input & ~history, evaluated combinationally.
  - History updates every cycle in every state.
  - Edges are acted on only as stated below; they are never queued.
- IDLE:
  - columns_reset = 1.
  - Start edge → PLAY next edge, with score_bcd = 0, lives = START_LIVES, playing = 1, columns_reset = 0.
- PLAY:
  - k = popcount of correct edges this cycle (0..NUM_COLUMNS).
  - m = popcount of game_over edges this cycle.
  - score_bcd += k in BCD (digit-wise add with decimal carry), saturating at 9999.
  - lives -= m, saturating at 0.
  - Correct and miss edges in the same cycle are both applied.
  - If lives − m <= 0 → OVER next edge (lives = 0, playing = 0, all_over = 1, columns_reset = 1). The score from that same cycle is still added.
  - Start edges are ignored.
- OVER:
  - On the first OVER cycle: if score_bcd > high_score_bcd, then high_score_bcd = score_bcd. The comparison is digit-wise BCD, equivalent to binary compare for valid BCD.
  - Score and lives are held.
  - Start edge → PLAY, clearing score and reloading lives.
  - A start edge coinciding with the first OVER cycle is honoured; the high-score update still occurs on that edge.
- Latency: the score/lives update is visible one clock after the input is first sampled high.
- A level held high counts once; it must fall and rise again to count again.
- An input already high when entering PLAY has no edge and does not count.
- BCD invariant: every digit is always 0..9. Illegal digits never appear, including at 0999→1000 and 9999 saturation.

Test Plan:
- Reset held low 3 cycles, then released → score_bcd=0x0000, high_score_bcd=0x0000, lives=3, playing=0, columns_reset=1. start pulse → next cycle playing=1, columns_reset=0.
- In PLAY, correct=3'b001 rises, held 10 cycles, then falls and rises again → score goes 0x0000→0x0001→0x0002; the held level adds nothing extra.
- Preload score to 0x0998 via 998 single edges (or a force), then correct=3'b111 rises → score_bcd=0x1001. Later, from 0x9998, a 3-column edge → 0x9999 (saturated).
- lives=3; same cycle correct=3'b010 and game_over=3'b101 rise → score+1, lives=1. Next game_over edge → lives=0, all_over=1, columns_reset=1, and high_score_bcd takes the final score if greater.
- Two games: first scores 0x0005, second 0x0003 → high_score_bcd stays 0x0005. Start edge in OVER → score 0x0000, lives 3, playing=1.
- reset_signal=0 for one cycle mid-PLAY with score 0x0042 → all values return to their reset values, including high_score_bcd=0x0000.
